bcd_to_bin: RTL and testbench

Sequential BCD-to-binary converter: the decode direction of the display path's binary-to-BCD encoder. It accepts a packed multi-digit BCD word on a start strobe and returns the binary value after a fixed number of cycles, using reverse double-dabble (shift right, subtract 3 from any digit ≥ 8). It sits between keypad/console digit-entry logic and the arithmetic datapath that needs plain binary operands.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_corr.sv | 17 +
 rtl/bcd_to_bin.sv | 122 ++++++++++++
 tb/tb_bcd_to_bin.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_t      : controller state encoding (IDLE / SHIFT / DONE)
//   BCD_MAX      : largest legal BCD digit value
//   CORR_THRESH  : digit value at or above which the reverse-dabble correction applies
//   CORR_SUB     : amount subtracted from a digit by that correction
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] CORR_THRESH = 4'd8;
  localparam logic [3:0] CORR_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit correction (combinational).
// Ports:
//   d : 4-bit digit after the right shift
//   q : d - 3 (mod 16) when d >= 8, otherwise d unchanged
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= CORR_THRESH) q = d - CORR_SUB;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble: each SHIFT
// cycle shifts {digits, binreg} right by one and then subtracts 3 from every
// digit that ended up >= 8. After 4*DIGITS iterations binreg holds the value.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : conversion request, sampled only in IDLE
//   bcd_in  : packed BCD word, [3:0] = ones digit
//   busy    : high while iterating (SHIFT)
//   done    : one-cycle result-valid pulse
//   bin_out : binary result, held until the next done
//   err     : invalid-digit flag, qualified by done
// Optional feature: define BCD_TO_BIN_ERR_EN to build the digit validity check
// (any digit > 9 yields err=1 and bin_out=0); otherwise err is tied low.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int NB    = 4 * DIGITS;
  localparam int CNT_W = $clog2(NB + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  state_t           state;
  logic [NB-1:0]    digits;
  logic [NB-1:0]    binreg;
  logic [CNT_W-1:0] cnt;

  logic [NB-1:0]    sh_dig;
  logic [NB-1:0]    sh_bin;
  logic [NB-1:0]    corr_dig;

  // One iteration: shift the whole {digits, binreg} chain right by one bit.
  always_comb begin
    {sh_dig, sh_bin} = {digits, binreg} >> 1;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .d (sh_dig[4*g +: 4]),
      .q (corr_dig[4*g +: 4])
    );
  end

`ifdef BCD_TO_BIN_ERR_EN
  logic bad_in;
  logic err_pend;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX) bad_in = 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Results are registered on the final SHIFT iteration so that done and
  // bin_out appear together in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      digits  <= '0;
      binreg  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
`ifdef BCD_TO_BIN_ERR_EN
      err      <= 1'b0;
      err_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            digits <= bcd_in;
            binreg <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
`ifdef BCD_TO_BIN_ERR_EN
            err_pend <= bad_in;
`endif
          end
        end
        ST_SHIFT: begin
          digits <= corr_dig;
          binreg <= sh_bin;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
`ifdef BCD_TO_BIN_ERR_EN
            err     <= err_pend;
            bin_out <= err_pend ? '0 : sh_bin[BIN_W-1:0];
`else
            bin_out <= sh_bin[BIN_W-1:0];
`endif
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    int          exp_bin;
    logic        exp_err;
    logic        chk_bin;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: digit-weighted sum; invalid if any nibble exceeds 9.
  function automatic int ref_val(input logic [11:0] w);
    return int'(w[11:8]) * 100 + int'(w[7:4]) * 10 + int'(w[3:0]);
  endfunction

  function automatic logic ref_bad(input logic [11:0] w);
    return (w[11:8] > 9) || (w[7:4] > 9) || (w[3:0] > 9);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Called at the negedge right after the accepting edge (cycle 1).
  task automatic wait_done(output logic [9:0] b, output logic e, output int lat,
                           output int bc);
    lat = 0; bc = 0; b = '0; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) bc++;
      if (done) begin
        lat = k; b = bin_out; e = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [11:0] v, output logic [9:0] b, output logic e,
                     output int lat, output int bc);
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'hFFF;
    wait_done(b, e, lat, bc);
  endtask

  logic [9:0]  rb;
  logic        re;
  int          lat, bc;
  logic        rt_ok;
  int          rt_bad;
  logic [11:0] w;
  logic        seen_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; bcd_in = 12'h000;
    #23;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_bin",  32'(bin_out), 0);
    chk("reset_err",  32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{12'h999, 999, 1'b0, 1'b1});
    vecs.push_back('{12'h000, 0,   1'b0, 1'b1});
    vecs.push_back('{12'h255, 255, 1'b0, 1'b1});
    vecs.push_back('{12'h042, 42,  1'b0, 1'b1});
`ifdef BCD_TO_BIN_ERR_EN
    vecs.push_back('{12'h1A3, 0,   1'b1, 1'b1});
`else
    vecs.push_back('{12'h1A3, 0,   1'b0, 1'b0});
`endif
    vecs.push_back('{12'h123, 123, 1'b0, 1'b1});
    vecs.push_back('{12'h808, 808, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      run(vecs[i].bcd, rb, re, lat, bc);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 13);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 12);
      if (vecs[i].chk_bin) chk($sformatf("vec%0d_bin", i), 32'(rb), 32'(vecs[i].exp_bin));
      chk($sformatf("vec%0d_err", i), 32'(re), 32'(vecs[i].exp_err));
    end

    // Exhaustive round trip against a decimal encoder.
    rt_bad = 0;
    for (int v = 0; v < 1000; v++) begin
      run(to_bcd(v), rb, re, lat, bc);
      rt_ok = (lat == 13) && (int'(rb) == v) && (re == 1'b0);
      if (!rt_ok) begin
        rt_bad++;
        if (rt_bad <= 5) $display("FAIL roundtrip v=%0d got bin %0d err %0d lat %0d", v, rb, re, lat);
      end
    end
    chk("roundtrip_bad_count", 32'(rt_bad), 0);

    // Random raw words, including illegal nibbles.
    for (int r = 0; r < 40; r++) begin
      w = 12'($urandom);
      run(w, rb, re, lat, bc);
      chk($sformatf("rand%0d_latency", r), 32'(lat), 13);
`ifdef BCD_TO_BIN_ERR_EN
      chk($sformatf("rand%0d_err", r), 32'(re), 32'(ref_bad(w)));
      chk($sformatf("rand%0d_bin", r), 32'(rb), ref_bad(w) ? 0 : 32'(ref_val(w)));
`else
      chk($sformatf("rand%0d_err", r), 32'(re), 0);
      if (!ref_bad(w)) chk($sformatf("rand%0d_bin", r), 32'(rb), 32'(ref_val(w)));
`endif
    end

    // start held through SHIFT and DONE with a different word: ignored.
    @(negedge clk);
    bcd_in = 12'h500; start = 1'b1;
    @(negedge clk);
    bcd_in = 12'h777;
    wait_done(rb, re, lat, bc);
    chk("hold_first_latency", 32'(lat), 13);
    chk("hold_first_bin", 32'(rb), 500);
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    chk("hold_accept_busy", 32'(busy), 1);
    wait_done(rb, re, lat, bc);
    chk("hold_second_latency", 32'(lat), 13);
    chk("hold_second_bin", 32'(rb), 777);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    bcd_in = 12'h999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bin",  32'(bin_out), 0);
    chk("abort_err",  32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 0);
    run(12'h042, rb, re, lat, bc);
    chk("after_abort_latency", 32'(lat), 13);
    chk("after_abort_bin", 32'(rb), 42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
